// File: rtl/timer_bank.sv
// Bank of independent up/down timer channels with prescaler, compare match,
// one-shot/periodic reload, cascade chaining and sticky interrupts.
module timer_bank #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          i_en,
    input  logic [NUM_CH-1:0]          i_count_up,
    input  logic [NUM_CH-1:0]          i_reload,
    input  logic [NUM_CH-1:0]          i_cascade,
    input  logic [NUM_CH*PRESC_W-1:0]  i_prescale,
    input  logic [NUM_CH*CNT_W-1:0]    i_load_value,
    input  logic [NUM_CH*CNT_W-1:0]    i_compare_value,
    input  logic [NUM_CH-1:0]          i_irq_clr,
    output logic [NUM_CH*CNT_W-1:0]    o_cnt_value,
    output logic [NUM_CH-1:0]          o_done,
    output logic [NUM_CH-1:0]          o_irq,
    output logic [NUM_CH-1:0]          o_running
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [NUM_CH-1:0] CH0_MASK = NUM_CH'(1);

    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] irq_q;
    logic [NUM_CH-1:0] casc_en;
    logic [NUM_CH-1:0] prev_done;

    // Channel 0 has no upstream neighbour, so its cascade bit is masked off.
    assign casc_en   = i_cascade & ~CH0_MASK;
    assign prev_done = done_q << 1;

    assign o_done = done_q;
    assign o_irq  = irq_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_t             state_q, state_d;
        logic [CNT_W-1:0]   value_q, value_d;
        logic [PRESC_W-1:0] psc_q, psc_d;
        logic               done_d;
        logic               irq_d;
        logic [CNT_W-1:0]   load_v;
        logic [CNT_W-1:0]   cmp_v;
        logic [PRESC_W-1:0] psc_v;
        logic               tick;
        logic               cnt_ev;

        assign load_v = i_load_value[k*CNT_W +: CNT_W];
        assign cmp_v  = i_compare_value[k*CNT_W +: CNT_W];
        assign psc_v  = i_prescale[k*PRESC_W +: PRESC_W];
        assign tick   = (psc_q == psc_v);
        assign cnt_ev = casc_en[k] ? prev_done[k] : tick;
        assign irq_d  = done_q[k] | (irq_q[k] & ~i_irq_clr[k]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= IDLE;
                value_q   <= '0;
                psc_q     <= '0;
                done_q[k] <= 1'b0;
                irq_q[k]  <= 1'b0;
            end else begin
                state_q   <= state_d;
                value_q   <= value_d;
                psc_q     <= psc_d;
                done_q[k] <= done_d;
                irq_q[k]  <= irq_d;
            end
        end

        always_comb begin
            state_d = state_q;
            value_d = value_q;
            psc_d   = psc_q;
            done_d  = 1'b0;
            if (!i_en[k]) begin
                state_d = IDLE;
                value_d = load_v;
                psc_d   = '0;
            end else begin
                case (state_q)
                    // IDLE already mirrors the load value; reloading here also
                    // makes the first run after reset start from the load value.
                    IDLE: begin
                        state_d = RUN;
                        value_d = load_v;
                    end
                    RUN: begin
                        psc_d = tick ? '0 : psc_q + 1'b1;
                        if (cnt_ev) begin
                            if (value_q == cmp_v) begin
                                done_d = 1'b1;
                                if (i_reload[k]) value_d = load_v;
                                else             state_d = EXPIRED;
                            end else if (i_count_up[k]) begin
                                value_d = value_q + 1'b1;
                            end else begin
                                value_d = value_q - 1'b1;
                            end
                        end
                    end
                    EXPIRED: ;
                    default: state_d = IDLE;
                endcase
            end
        end

        always_comb begin
            o_running[k] = (state_q == RUN);
        end

        assign o_cnt_value[k*CNT_W +: CNT_W] = value_q;
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: periodic, one-shot, cascade, wrap, irq and reset.
module tb_timer_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  en, up, reload, cascade, clr;
    logic [7:0]  prescale;
    logic [15:0] load, cmp;
    logic [15:0] cnt;
    logic [1:0]  done, irq, running;

    int total = 0;
    int bad   = 0;

    timer_bank #(.NUM_CH(2), .CNT_W(8), .PRESC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_count_up(up), .i_reload(reload),
        .i_cascade(cascade), .i_prescale(prescale), .i_load_value(load),
        .i_compare_value(cmp), .i_irq_clr(clr), .o_cnt_value(cnt), .o_done(done),
        .o_irq(irq), .o_running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg0(input bit u, input bit r, input int p, input int l, input int c);
        up[0]         = u;
        reload[0]     = r;
        prescale[3:0] = 4'(p);
        load[7:0]     = 8'(l);
        cmp[7:0]      = 8'(c);
    endtask

    initial begin
        int m;
        bit ev1;
        rst_n = 1'b0; en = '0; up = '0; reload = '0; cascade = '0; clr = '0;
        prescale = '0; load = '0; cmp = '0;
        #3;
        check("rst_cnt", int'(cnt), 0);
        check("rst_run", int'(running), 0);
        check("rst_done", int'(done), 0);
        check("rst_irq", int'(irq), 0);

        // Periodic up count 0..5 with prescale 0
        cfg0(1, 1, 0, 0, 5);
        #9 rst_n = 1'b1;
        step();
        en[0] = 1'b1;
        step();
        check("per_run", int'(running[0]), 1);
        check("per_v0", int'(cnt[7:0]), 0);
        for (int i = 1; i <= 12; i++) begin
            step();
            check("per_val", int'(cnt[7:0]), i % 6);
            check("per_done", int'(done[0]), (i % 6 == 0) ? 1 : 0);
            check("per_irq", int'(irq[0]), (i >= 7) ? 1 : 0);
        end

        // One-shot down count, prescale 3
        en[0] = 1'b0;
        cfg0(0, 0, 3, 2, 0);
        step();
        check("os_idle_val", int'(cnt[7:0]), 2);
        check("os_idle_run", int'(running[0]), 0);
        en[0] = 1'b1;
        step();
        check("os_start", int'(cnt[7:0]), 2);
        for (int j = 1; j <= 16; j++) begin
            step();
            check("os_val", int'(cnt[7:0]), (j < 4) ? 2 : (j < 8) ? 1 : 0);
            check("os_done", int'(done[0]), (j == 12) ? 1 : 0);
            check("os_run", int'(running[0]), (j < 12) ? 1 : 0);
        end
        en[0] = 1'b0;
        step();
        check("os_off_val", int'(cnt[7:0]), 2);
        en[0] = 1'b1;
        step();
        check("os_restart_run", int'(running[0]), 1);
        check("os_restart_val", int'(cnt[7:0]), 2);

        // Cascade: ch1 counts ch0 matches
        en = '0;
        cfg0(1, 1, 0, 0, 1);
        up[1] = 1'b1; reload[1] = 1'b1; cascade[1] = 1'b1;
        prescale[7:4] = 4'd0; load[15:8] = 8'd0; cmp[15:8] = 8'd2;
        step();
        en = 2'b11;
        step();
        check("cas_run", int'(running), 3);
        for (int e = 2; e <= 16; e++) begin
            step();
            ev1 = (e % 2 == 0) && (e >= 4);
            m   = (e >= 4) ? (e - 2) / 2 : 0;
            check("cas_v0", int'(cnt[7:0]), (e % 2 == 0) ? 1 : 0);
            check("cas_v1", int'(cnt[15:8]), m % 3);
            check("cas_d1", int'(done[1]), (ev1 && (m % 3 == 0)) ? 1 : 0);
        end
        en = '0; cascade = '0;

        // Wrap from all-ones, then irq set/clear interplay
        cfg0(1, 1, 0, 255, 1);
        step();
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        check("irq_clr_alone", int'(irq[0]), 0);
        en[0] = 1'b1;
        step();
        check("wrap_start", int'(cnt[7:0]), 255);
        step();
        check("wrap_zero", int'(cnt[7:0]), 0);
        step();
        check("wrap_one", int'(cnt[7:0]), 1);
        check("wrap_nodone", int'(done[0]), 0);
        step();
        check("wrap_done", int'(done[0]), 1);
        check("wrap_reload", int'(cnt[7:0]), 255);
        step();
        check("irq_set", int'(irq[0]), 1);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        check("irq_cleared", int'(irq[0]), 0);
        step();
        check("irq_done6", int'(done[0]), 1);
        step();
        check("irq_reset", int'(irq[0]), 1);
        step();
        step();
        check("irq_done9", int'(done[0]), 1);
        clr[0] = 1'b1;
        step();
        check("irq_set_wins", int'(irq[0]), 1);
        step();
        clr[0] = 1'b0;
        check("irq_clr_after", int'(irq[0]), 0);

        // Async reset mid-run at value 7
        en[0] = 1'b0;
        cfg0(1, 1, 0, 3, 20);
        step();
        en[0] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_val", int'(cnt[7:0]), 7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cnt", int'(cnt), 0);
        check("arst_run", int'(running), 0);
        check("arst_done", int'(done), 0);
        check("arst_irq", int'(irq), 0);
        #2 rst_n = 1'b1;
        step();
        check("post_rst_run", int'(running[0]), 1);
        check("post_rst_val", int'(cnt[7:0]), 3);
        step();
        check("post_rst_inc", int'(cnt[7:0]), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
